// File: rtl/range_match_tree_level.sv
`default_nettype none
// ============================================================================
// Module   : range_match_tree_level
// Purpose  : One pipelined level of the range-match search tree. It compares
//            the header field against the current node's boundary and emits
//            the child index. The output stage has a one-entry skid buffer.
// Options  : RMT_LEVEL_STATS_EN adds the lt_count statistics port.
// Revision : 1.0 - initial release
// ============================================================================
module range_match_tree_level #(
    parameter int data_width = 8,
    parameter int level      = 2,
    parameter int idx_width  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] in_data,
    input  logic [idx_width-1:0]  in_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_data,
    output logic [idx_width:0]    out_idx,
    input  logic                  cfg_we,
    input  logic [idx_width-1:0]  cfg_addr,
    input  logic [data_width-1:0] cfg_wdata
`ifdef RMT_LEVEL_STATS_EN
    ,
    output logic [15:0]           lt_count
`endif
);

    localparam int c_nodes = 1 << level;

    logic [data_width-1:0] r_bound [c_nodes];
    logic [data_width-1:0] w_target;
    logic [idx_width-1:0]  w_node;
    logic                  w_lt;
    logic [idx_width:0]    w_res_idx;
    logic                  w_accept;
    logic                  w_consume;

    logic                  r_out_valid;
    logic [data_width-1:0] r_out_data;
    logic [idx_width:0]    r_out_idx;
    logic                  r_skid_valid;
    logic [data_width-1:0] r_skid_data;
    logic [idx_width:0]    r_skid_idx;

    // The root level has a single node, so the incoming index carries nothing.
    generate
        if (level == 0) begin : g_root
            assign w_target = r_bound[0];
            assign w_node   = '0;
        end else begin : g_inner
            assign w_target = r_bound[in_idx];
            assign w_node   = in_idx;
        end
    endgenerate

    assign w_lt      = (in_data < w_target);
    assign w_res_idx = {w_node, ~w_lt};
    assign w_accept  = in_valid & ~r_skid_valid;
    assign w_consume = r_out_valid & out_ready;

    // Addresses beyond the node count never match and are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_nodes; i++) begin
                r_bound[i] <= '0;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < c_nodes; i++) begin
                if (cfg_addr == idx_width'(i)) begin
                    r_bound[i] <= cfg_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_idx    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_idx   <= '0;
        end else begin
            if (!r_out_valid || w_consume) begin
                if (r_skid_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_skid_data;
                    r_out_idx   <= r_skid_idx;
                end else if (w_accept) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= in_data;
                    r_out_idx   <= w_res_idx;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end

            if (r_skid_valid) begin
                if (w_consume) begin
                    r_skid_valid <= 1'b0;
                end
            end else if (w_accept && r_out_valid && !out_ready) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= in_data;
                r_skid_idx   <= w_res_idx;
            end
        end
    end

    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;

`ifdef RMT_LEVEL_STATS_EN
    logic [15:0] r_lt_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lt_count <= '0;
        end else if (w_accept && w_lt && (r_lt_count != 16'hFFFF)) begin
            r_lt_count <= r_lt_count + 16'd1;
        end
    end

    assign lt_count = r_lt_count;
`endif

endmodule
`default_nettype wire
